// File: rtl/mclk_mon_pkg.sv
// Shared definitions for the master-clock health monitor.
//   mon_state_e : qualification FSM encoding (DOWN / QUAL / UP)
//   DTC_* / ETH_* : default window and bound settings for the two instances
package mclk_mon_pkg;

  typedef enum logic [1:0] {
    MON_DOWN = 2'd0,
    MON_QUAL = 2'd1,
    MON_UP   = 2'd2
  } mon_state_e;

  localparam int unsigned DEF_CNT_W    = 16;

  localparam int unsigned DTC_WIN_CYC  = 4096;
  localparam int unsigned DTC_CNT_LO   = 920;
  localparam int unsigned DTC_CNT_HI   = 1128;
  localparam int unsigned DTC_GOOD_WIN = 4;

  localparam int unsigned ETH_WIN_CYC  = 4096;
  localparam int unsigned ETH_CNT_LO   = 920;
  localparam int unsigned ETH_CNT_HI   = 1128;
  localparam int unsigned ETH_GOOD_WIN = 4;

endpackage

// File: rtl/mclk_sync.sv
// N-stage flop synchroniser with asynchronous active-high reset.
//   clk_i : destination clock
//   rst_i : asynchronous reset, clears every stage to 0
//   d_i   : asynchronous input
//   q_o   : all stages, q_o[0] is the first flop, q_o[N-1] the last
module mclk_sync #(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] stage_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[N-2:0], d_i};
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/mclk_monitor.sv
// Clock-health monitor in the clk0 reference domain. Counts edges of a slow
// toggle from the monitored domain over a fixed window, checks the count
// against bounds and qualifies the clock after GOOD_WIN good windows.
//   clk0       : reference clock
//   rst        : asynchronous active-high reset
//   enable     : monitor enable (clk0 domain)
//   mon_tgl    : asynchronous toggle from the monitored domain
//   mon_locked : asynchronous PLL/DCM lock of the monitored clock
//   clk_ok     : monitored clock qualified
//   meas_cnt   : edge count of the last completed window
//   meas_valid : one-cycle pulse when meas_cnt updates
//   drop_cnt   : saturating count of UP->DOWN transitions
module mclk_monitor
  import mclk_mon_pkg::*;
#(
  parameter int unsigned WIN_CYC  = DTC_WIN_CYC,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned CNT_LO   = DTC_CNT_LO,
  parameter int unsigned CNT_HI   = DTC_CNT_HI,
  parameter int unsigned GOOD_WIN = DTC_GOOD_WIN
) (
  input  logic             clk0,
  input  logic             rst,
  input  logic             enable,
  input  logic             mon_tgl,
  input  logic             mon_locked,
  output logic             clk_ok,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_valid,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned WIN_W  = $clog2(WIN_CYC);
  localparam int unsigned GOOD_W = $clog2(GOOD_WIN + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [GOOD_W-1:0] GOOD_PRE = GOOD_W'(GOOD_WIN - 1);

  logic [2:0] tgl_sync;
  logic [1:0] lock_sync;
  logic       edge_det;
  logic       locked_s;
  logic       unused_sync;

  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              bad_flag_q, bad_flag_d;
  logic [CNT_W-1:0]  cnt_fin;
  logic              win_end;
  logic              in_range;
  logic              win_good;
  logic [GOOD_W-1:0] good_cnt_q;
  mon_state_e        state_q;

  mclk_sync #(.N(3)) u_sync_tgl (
    .clk_i (clk0),
    .rst_i (rst),
    .d_i   (mon_tgl),
    .q_o   (tgl_sync)
  );

  mclk_sync #(.N(2)) u_sync_lock (
    .clk_i (clk0),
    .rst_i (rst),
    .d_i   (mon_locked),
    .q_o   (lock_sync)
  );

  // Edge = stage2 XOR stage3, so both toggle directions count.
  assign edge_det    = tgl_sync[1] ^ tgl_sync[2];
  assign locked_s    = lock_sync[1];
  assign unused_sync = tgl_sync[0] ^ lock_sync[0];

  // Window bookkeeping and the good/bad verdict for the closing window.
  always_comb begin
    win_end = enable && (win_cnt_q == WIN_LAST);

    // Count including this cycle's edge, saturating at all-ones.
    cnt_fin = edge_cnt_q;
    if (edge_det && (edge_cnt_q != CNT_MAX)) begin
      cnt_fin = edge_cnt_q + CNT_W'(1);
    end

    in_range = (32'(cnt_fin) >= CNT_LO) && (32'(cnt_fin) <= CNT_HI);
    win_good = in_range && (cnt_fin != CNT_MAX) && !bad_flag_q && locked_s;

    win_cnt_d  = '0;
    edge_cnt_d = '0;
    bad_flag_d = 1'b0;
    if (enable && !win_end) begin
      win_cnt_d  = win_cnt_q + WIN_W'(1);
      edge_cnt_d = cnt_fin;
      bad_flag_d = bad_flag_q | !locked_s;
    end
  end

  // Window / measurement registers; meas_cnt holds while disabled.
  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      bad_flag_q <= 1'b0;
      meas_cnt   <= '0;
      meas_valid <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      bad_flag_q <= bad_flag_d;
      meas_valid <= win_end;
      if (win_end) begin
        meas_cnt <= cnt_fin;
      end
    end
  end

  // Qualification FSM with registered clk_ok and drop counter.
  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      state_q    <= MON_DOWN;
      good_cnt_q <= '0;
      clk_ok     <= 1'b0;
      drop_cnt   <= '0;
    end else if (!enable) begin
      // Disabling is not a clock failure, so drop_cnt is left alone.
      state_q    <= MON_DOWN;
      good_cnt_q <= '0;
      clk_ok     <= 1'b0;
    end else begin
      case (state_q)
        MON_DOWN: begin
          if (win_end && win_good) begin
            good_cnt_q <= GOOD_W'(1);
            if (GOOD_WIN == 1) begin
              state_q <= MON_UP;
              clk_ok  <= 1'b1;
            end else begin
              state_q <= MON_QUAL;
            end
          end
        end
        MON_QUAL: begin
          if (!locked_s || (win_end && !win_good)) begin
            state_q    <= MON_DOWN;
            good_cnt_q <= '0;
          end else if (win_end) begin
            good_cnt_q <= good_cnt_q + GOOD_W'(1);
            if (good_cnt_q == GOOD_PRE) begin
              state_q <= MON_UP;
              clk_ok  <= 1'b1;
            end
          end
        end
        MON_UP: begin
          if (!locked_s || (win_end && !win_good)) begin
            state_q    <= MON_DOWN;
            good_cnt_q <= '0;
            clk_ok     <= 1'b0;
            if (drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
          end
        end
        default: begin
          state_q    <= MON_DOWN;
          good_cnt_q <= '0;
          clk_ok     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mclk_monitor.sv
// Randomised self-checking bench for mclk_monitor. Two instances share
// clk0/rst/enable/mon_locked: dut_a (CNT_W=16) gets a variable-period toggle,
// dut_b (CNT_W=8) a fixed 2-cycle toggle that saturates its counter.
module tb_mclk_monitor;

  localparam int WIN  = 1000;
  localparam int LO   = 240;
  localparam int HI   = 260;
  localparam int GW   = 4;
  localparam int NCYC = 60000;

  logic        clk0 = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        mon_locked = 1'b0;
  logic        tgl_a = 1'b0;
  logic        tgl_b = 1'b0;
  logic        ok_a, ok_b, mv_a, mv_b;
  logic [15:0] mc_a;
  logic [7:0]  mc_b, dc_a, dc_b;

  always #5 clk0 = ~clk0;

  mclk_monitor #(.WIN_CYC(WIN), .CNT_W(16), .CNT_LO(LO), .CNT_HI(HI), .GOOD_WIN(GW)) dut_a (
    .clk0(clk0), .rst(rst), .enable(enable), .mon_tgl(tgl_a), .mon_locked(mon_locked),
    .clk_ok(ok_a), .meas_cnt(mc_a), .meas_valid(mv_a), .drop_cnt(dc_a)
  );

  mclk_monitor #(.WIN_CYC(WIN), .CNT_W(8), .CNT_LO(LO), .CNT_HI(HI), .GOOD_WIN(GW)) dut_b (
    .clk0(clk0), .rst(rst), .enable(enable), .mon_tgl(tgl_b), .mon_locked(mon_locked),
    .clk_ok(ok_b), .meas_cnt(mc_b), .meas_valid(mv_b), .drop_cnt(dc_b)
  );

  // Stimulus knobs
  bit rst_r = 1'b1, en_r = 1'b0, lock_r = 1'b1, chk_dir = 1'b0;
  int per_a = 4;
  int tc[2];
  bit tv[2];

  // Sampled history of the asynchronous inputs (0 while in reset)
  bit th[2][NCYC];
  bit lh[NCYC];
  int cyc = 0;

  // Reference model state
  int m_wc, m_acc[2], m_run[2], m_drop[2], m_mcnt[2];
  bit m_ok[2], m_mv[2], m_lkbad;
  int cmax[2] = '{65535, 255};

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    else n_pass++;
  endtask

  function automatic bit tg(int i, int k);
    return (k < 0) ? 1'b0 : th[i][k];
  endfunction

  function automatic bit lk(int k);
    return (k < 0) ? 1'b0 : lh[k];
  endfunction

  // One clk0 cycle: drive on negedge, update model on posedge, compare #1 later.
  task automatic step();
    int  p, tot, cnt;
    bit  lks, we, e, good;
    if (cyc >= NCYC) begin
      $display("FAIL cycle_budget: got %0d, expected < %0d", cyc, NCYC);
      $fatal(1);
    end
    @(negedge clk0);
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? per_a : 2;
      if (p != 0) begin
        tc[i]++;
        if (tc[i] >= p) begin
          tc[i] = 0;
          tv[i] = !tv[i];
        end
      end
    end
    tgl_a      = tv[0];
    tgl_b      = tv[1];
    mon_locked = lock_r;
    enable     = en_r;
    if (rst_r && !rst) begin
      rst = 1'b1;
      #1;
      chk("rst_clk_ok_a", ok_a, 0);
      chk("rst_meas_valid_a", mv_a, 0);
      chk("rst_meas_cnt_a", mc_a, 0);
      chk("rst_drop_a", dc_a, 0);
      chk("rst_clk_ok_b", ok_b, 0);
      chk("rst_meas_cnt_b", mc_b, 0);
    end else begin
      rst = rst_r;
    end
    th[0][cyc] = rst_r ? 1'b0 : tv[0];
    th[1][cyc] = rst_r ? 1'b0 : tv[1];
    lh[cyc]    = rst_r ? 1'b0 : lock_r;

    @(posedge clk0);
    if (rst_r) begin
      m_wc = 0;
      m_lkbad = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0; m_run[i] = 0; m_ok[i] = 1'b0;
        m_drop[i] = 0; m_mcnt[i] = 0; m_mv[i] = 1'b0;
      end
    end else begin
      // Inputs reach the logic two cycles after being sampled.
      lks = lk(cyc - 2);
      we  = en_r && (m_wc == WIN - 1);
      for (int i = 0; i < 2; i++) begin
        e = (tg(i, cyc - 2) != tg(i, cyc - 3));
        m_mv[i] = we;
        if (!en_r) begin
          m_acc[i] = 0; m_run[i] = 0; m_ok[i] = 1'b0;
        end else begin
          tot  = m_acc[i] + int'(e);
          good = 1'b0;
          if (we) begin
            cnt = (tot > cmax[i]) ? cmax[i] : tot;
            good = (cnt >= LO) && (cnt <= HI) && (cnt != cmax[i]) && !m_lkbad && lks;
            m_mcnt[i] = cnt;
            m_acc[i]  = 0;
          end else begin
            m_acc[i] = tot;
          end
          if (!lks || (we && !good)) begin
            if (m_ok[i] && m_drop[i] < 255) m_drop[i]++;
            m_ok[i] = 1'b0;
            m_run[i] = 0;
          end else if (we) begin
            if (m_run[i] < GW) m_run[i]++;
            if (m_run[i] >= GW) m_ok[i] = 1'b1;
          end
        end
      end
      m_lkbad = (en_r && !we) ? (m_lkbad || !lks) : 1'b0;
      m_wc    = (en_r && !we) ? m_wc + 1 : 0;
    end
    #1;
    chk("clk_ok_a", ok_a, m_ok[0]);
    chk("meas_valid_a", mv_a, m_mv[0]);
    chk("meas_cnt_a", mc_a, m_mcnt[0]);
    chk("drop_cnt_a", dc_a, m_drop[0]);
    chk("clk_ok_b", ok_b, m_ok[1]);
    chk("meas_valid_b", mv_b, m_mv[1]);
    chk("meas_cnt_b", mc_b, m_mcnt[1]);
    chk("drop_cnt_b", dc_b, m_drop[1]);
    if (chk_dir && mv_a) chk("nominal_cnt", mc_a, 250);
    if (chk_dir && mv_b) chk("saturated_cnt", mc_b, 255);
    cyc++;
  endtask

  initial begin
    int n;
    bit got;

    // Reset with toggles already running
    repeat (5) step();
    rst_r = 1'b0;
    repeat (20) step();

    // Nominal lock-in: clk_ok after GOOD_WIN full windows
    en_r = 1'b1;
    chk_dir = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 4200 && !got) begin
      step();
      n++;
      if (ok_a) got = 1'b1;
    end
    chk("lockin_latency", n, GW * WIN);
    repeat (2 * WIN) step();
    chk_dir = 1'b0;

    // Frequency too high (toggle every 3 cycles)
    per_a = 3;
    repeat (3 * WIN) step();
    chk("freq_clk_ok", ok_a, 0);
    chk("freq_drop", dc_a, 1);

    // Back to nominal: four windows to requalify
    per_a = 4;
    repeat (4 * WIN) step();
    chk("requal_clk_ok", ok_a, 1);

    // One-cycle lock drop in UP
    repeat (300) step();
    lock_r = 1'b0;
    step();
    lock_r = 1'b1;
    step();
    chk("lock_edge2_ok", ok_a, 1);
    step();
    chk("lock_edge3_ok", ok_a, 0);
    chk("lock_drop", dc_a, 2);
    repeat (WIN - 303 + 4 * WIN - 1) step();
    chk("lock_requal_early", ok_a, 0);
    step();
    chk("lock_requal", ok_a, 1);

    // Enable low in UP: no drop counted
    en_r = 1'b0;
    repeat (50) step();
    chk("dis_clk_ok", ok_a, 0);
    chk("dis_drop", dc_a, 2);
    en_r = 1'b1;

    // QUAL interrupted by a dead window after two good ones
    repeat (2 * WIN) step();
    per_a = 0;
    repeat (WIN) step();
    chk("qual_bad_ok", ok_a, 0);
    per_a = 4;
    repeat (3 * WIN) step();
    chk("qual_three_ok", ok_a, 0);
    repeat (WIN) step();
    chk("qual_four_ok", ok_a, 1);

    // Reset mid-window
    repeat (437) step();
    rst_r = 1'b1;
    step();
    repeat (3) step();
    rst_r = 1'b0;

    // Random segments: period, lock glitches and enable drops
    for (int s = 0; s < 14; s++) begin
      per_a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 5)) : 4;
      en_r  = ($urandom_range(0, 7) != 0);
      n = int'($urandom_range(200, 1500));
      for (int k = 0; k < n; k++) begin
        lock_r = ($urandom_range(0, 1999) != 0);
        step();
      end
      lock_r = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
